// File: rtl/prime_pkg.sv
// Shared types and default sizing for the prime table generator and its table RAM.
package prime_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_OUTER,
    S_MARK,
    S_COLLECT,
    S_DONE
  } state_t;

  localparam int N_MAX_DEF      = 1024;
  localparam int MAX_PRIMES_DEF = 172;
  localparam int VAL_W_DEF      = 10;
  localparam int IDX_W_DEF      = 8;

  // External table indices are 1-based; RAM addresses are 0-based.
  localparam int TABLE_BASE = 1;

endpackage

// File: rtl/prime_table_ram.sv
// Single-write, single-read table memory with a registered read port.
module prime_table_ram #(
  parameter int DEPTH  = 172,
  parameter int DATA_W = 10,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Out-of-range addresses read as zero so the caller never sees X.
  always_comb begin
    rdata_d = '0;
    if (raddr < ADDR_W'(DEPTH)) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prime_table_gen.sv
// Sieve of Eratosthenes over 0..N_MAX-1, compacted into a 1-based prime table
// that is read back through a registered port once the build is done.
module prime_table_gen
  import prime_pkg::*;
#(
  parameter int N_MAX      = N_MAX_DEF,
  parameter int MAX_PRIMES = MAX_PRIMES_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] prime_count,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [VAL_W-1:0] rd_prime,
  output logic             rd_valid
);

  state_t              state_q, state_d;
  logic [N_MAX-1:0]    flags_q, flags_d;
  logic [VAL_W-1:0]    i_q, i_d;
  logic [VAL_W:0]      j_q, j_d;
  logic [VAL_W-1:0]    k_q, k_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    prime_count_q, prime_count_d;
  logic                rd_valid_q, rd_valid_d;

  logic [2*VAL_W-1:0]  i_sq;
  logic [VAL_W:0]      j_next;
  logic                tbl_we;
  logic [IDX_W-1:0]    tbl_waddr;
  logic [VAL_W-1:0]    tbl_rdata;

  assign i_sq   = {{VAL_W{1'b0}}, i_q} * {{VAL_W{1'b0}}, i_q};
  assign j_next = j_q + {1'b0, i_q};

  always_comb begin
    state_d       = state_q;
    flags_d       = flags_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    count_d       = count_q;
    prime_count_d = prime_count_q;
    tbl_we        = 1'b0;
    tbl_waddr     = count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        flags_d    = '1;
        flags_d[0] = 1'b0;
        flags_d[1] = 1'b0;
        i_d        = VAL_W'(2);
        count_d    = '0;
        state_d    = S_OUTER;
      end
      S_OUTER: begin
        if (i_sq >= (2*VAL_W)'(N_MAX)) begin
          k_d     = VAL_W'(2);
          state_d = S_COLLECT;
        end else if (flags_q[i_q]) begin
          j_d     = i_sq[VAL_W:0];
          state_d = S_MARK;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_MARK: begin
        flags_d[j_q[VAL_W-1:0]] = 1'b0;
        if (j_next >= (VAL_W+1)'(N_MAX)) begin
          i_d     = i_q + 1'b1;
          state_d = S_OUTER;
        end else begin
          j_d = j_next;
        end
      end
      S_COLLECT: begin
        // Writes past the table depth are dropped and the count saturates.
        if (flags_q[k_q] && (count_q < IDX_W'(MAX_PRIMES))) begin
          tbl_we  = 1'b1;
          count_d = count_q + 1'b1;
        end
        if (k_q == VAL_W'(N_MAX-1)) begin
          prime_count_d = count_d;
          state_d       = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_valid_d = (state_q == S_DONE) && (rd_idx != '0) && (rd_idx <= prime_count_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      prime_count_q <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      prime_count_q <= prime_count_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Sieve datapath carries no reset; it is rebuilt in CLEAR on every start.
  always_ff @(posedge clk) begin
    flags_q <= flags_d;
    i_q     <= i_d;
    j_q     <= j_d;
    k_q     <= k_d;
  end

  prime_table_ram #(
    .DEPTH  (MAX_PRIMES),
    .DATA_W (VAL_W),
    .ADDR_W (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_waddr),
    .wdata (k_q),
    .raddr (rd_idx - IDX_W'(TABLE_BASE)),
    .rdata (tbl_rdata)
  );

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign prime_count = prime_count_q;
  assign rd_valid    = rd_valid_q;
  assign rd_prime    = rd_valid_q ? tbl_rdata : '0;

endmodule
